axi_window_read_responder: RTL
==============================

Name: axi_window_read_responder

Overview:
AXI4 read-only slave serving a window buffer of 256-bit entries. It is the responder at the far end of the AXI read channel that the debug AXI reader drives. A local write port fills the buffer. AR requests are accepted one at a time, and each returns arlen+1 R beats at full throughput with one-cycle fetch latency.

Parameters:
DATA_BYTE_WIDTH, 32, bytes per entry/beat; the data bus is DATA_BYTE_WIDTH*8 = 256 bits.
DATA_BYTE_SHIFT, 5, log2(DATA_BYTE_WIDTH); entry index = araddr >> DATA_BYTE_SHIFT.
DEPTH, 100, number of entries.
DEPTH_INDEX, 7, index width; 2**DEPTH_INDEX >= DEPTH.
ID_WIDTH, 4, AXI ID width.

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  local write strobe
wr_addr  in  DEPTH_INDEX  write entry index; ignored if >= DEPTH
wr_data  in  DATA_BYTE_WIDTH*8  write data
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  32  byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  beat size
s_axi_arburst  in  2  burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  returned ID
s_axi_rdata  out  DATA_BYTE_WIDTH*8  read data
s_axi_rresp  out  2  response
s_axi_rlast  out  1  last beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
busy  out  1  high while a burst is in progress

Behaviour:
- Reset values: arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0, busy=0; state=IDLE. Buffer contents are not cleared and persist across reset.
- arready comes from registers only: it is 1 in IDLE except in the first cycle after reset release, when it is 0.
- States:
  - IDLE to BURST on arvalid&&arready. At that edge, latch arid, arburst, arsize, arlen into beats_left; latch idx = araddr>>DATA_BYTE_SHIFT; set busy=1.
  - BURST: the fetch condition is (!rvalid || rready) && beats_left_valid. When it holds:
    - rdata <= mem[idx] and rvalid <= 1.
    - rlast <= (beat count == arlen).
    - idx advances by +1 for INCR and stays unchanged for FIXED.
    - rid is set to the latched ID.
  - When rready is high with no beat left, rvalid <= 0.
  - BURST to IDLE at the edge where the rlast beat handshakes: rvalid=0 and busy=0 at that edge, arready=1 the next cycle.
- Timing:
  - Latency: AR handshake at edge T, first rvalid at edge T+1.
  - Back-to-back beats with rready held high.
  - rvalid/rdata/rlast stay stable while rready is low.
- AR is never accepted while busy. At most one outstanding burst.
- Read/write collision on the same index in the same cycle is read-first: the beat returns old data. Writes are never blocked.
- Index arithmetic is DEPTH_INDEX bits wide.
- arlen=255 yields 256 beats. The beat counter is 8 bits and must not overflow early.
- Reset asserted mid-burst: outputs return to reset values immediately (async). No further beats are issued; the burst is abandoned.

Optional Feature:
Macro AXI_WINDOW_RESPONDER_ERR_EN.
- Defined: a beat gets rresp=2'b10 (SLVERR) and rdata=0 when its idx >= DEPTH, when arsize != DATA_BYTE_SHIFT, or when arburst is WRAP or reserved. The full arlen+1 beats are still returned, and rlast is still correct.
- Undefined:
  - rresp is always OKAY.
  - arsize is ignored.
  - WRAP and reserved bursts are treated as INCR.
  - idx wraps to 0 on reaching DEPTH.

Test Plan:
- Write entries 0..3 with 256'h0..03. AR araddr=0x00, arlen=3, INCR, arid=5 with rready=1 -> 4 consecutive beats of data 0,1,2,3 with rid=5, rlast only on beat 4, rresp=0. First rvalid comes one cycle after the AR handshake.
- Same burst with rready toggling 1,0,0,1... -> rdata/rlast held stable during stalls, no beat lost or duplicated, arready=0 until the last beat handshakes.
- FIXED burst, araddr=0x40, arlen=2 -> three beats each equal to entry 2.
- Write entry 1 to 'hAA, then in the same cycle as the fetch of idx 1 write 'hBB -> that beat returns 'hAA; a later read returns 'hBB.
- ERR_EN defined, araddr=99<<5, arlen=1 -> beat 1 OKAY with entry 99, beat 2 SLVERR with data 0, rlast on beat 2. ERR_EN undefined -> beat 2 returns entry 0 with OKAY.
- Assert rst_n=0 after beat 2 of an 8-beat burst -> rvalid=0 and arready=0 immediately. After release, arready=1 on the second cycle, and a new burst is served correctly.

Source files
------------

// File: rtl/axi_window_read_responder.sv
// axi_window_read_responder: AXI4 read-only slave over a 256-bit window buffer.
// A local write port fills the buffer. One AR burst is in flight at a time.
// The slave returns arlen+1 beats at full rate, with one cycle of fetch latency.
// Optional build macro AXI_WINDOW_RESPONDER_ERR_EN turns on SLVERR for these beats:
// out-of-window beats, beats with an arsize mismatch, and WRAP/reserved bursts.
module axi_window_read_responder #(
  parameter int unsigned DATA_BYTE_WIDTH = 32,
  parameter int unsigned DATA_BYTE_SHIFT = 5,
  parameter int unsigned DEPTH           = 100,
  parameter int unsigned DEPTH_INDEX     = 7,
  parameter int unsigned ID_WIDTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DEPTH_INDEX-1:0]       wr_addr,
  input  logic [DATA_BYTE_WIDTH*8-1:0] wr_data,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [31:0]                  s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_BYTE_WIDTH*8-1:0] s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic                         busy
);

  localparam int unsigned          DW          = DATA_BYTE_WIDTH * 8;
  localparam logic [DEPTH_INDEX:0] DEPTH_W     = (DEPTH_INDEX + 1)'(DEPTH);
  localparam logic [DEPTH_INDEX:0] ONE_W       = (DEPTH_INDEX + 1)'(1);
  localparam logic [2:0]           SIZE_FULL   = 3'(DATA_BYTE_SHIFT);
  localparam logic [1:0]           BURST_FIXED = 2'b00;
  localparam logic [1:0]           RESP_OKAY   = 2'b00;
  localparam logic [1:0]           RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, BURST} state_e;

  state_e                 state_q, state_d;
  logic                   arready_q, arready_d;
  logic                   busy_q, busy_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rlast_q, rlast_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]    rid_q, rid_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [1:0]             burst_q, burst_d;
  logic [2:0]             size_q, size_d;
  logic [7:0]             len_q, len_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [DEPTH_INDEX-1:0] idx_q, idx_d;

  logic [DW-1:0]          mem [DEPTH];
  logic [DW-1:0]          mem_rd;
  logic                   idx_in_range;
  logic [DEPTH_INDEX:0]   idx_inc;
  logic [DEPTH_INDEX-1:0] idx_next;
  logic                   beat_err;
  logic                   unused_bits;

  assign unused_bits = ^{s_axi_araddr[31:DATA_BYTE_SHIFT+DEPTH_INDEX],
                         s_axi_araddr[DATA_BYTE_SHIFT-1:0], size_q};

  // Local write port: no reset, so contents survive rst_n; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) mem[wr_addr] <= wr_data;
  end

  // Per-beat read, error qualification and next-index arithmetic.
  always_comb begin
    idx_in_range = ({1'b0, idx_q} < DEPTH_W);
    mem_rd       = idx_in_range ? mem[idx_q] : '0;
    idx_inc      = {1'b0, idx_q} + ONE_W;
`ifdef AXI_WINDOW_RESPONDER_ERR_EN
    beat_err = !idx_in_range || (size_q != SIZE_FULL) || burst_q[1];
    idx_next = (burst_q == BURST_FIXED) ? idx_q : idx_inc[DEPTH_INDEX-1:0];
`else
    beat_err = 1'b0;
    if (burst_q == BURST_FIXED)  idx_next = idx_q;
    else if (idx_inc >= DEPTH_W) idx_next = '0;
    else                         idx_next = idx_inc[DEPTH_INDEX-1:0];
`endif
  end

  // Control FSM: accept one AR in IDLE, then stream beats until the rlast handshake.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    busy_d    = busy_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    id_d      = id_q;
    burst_d   = burst_q;
    size_d    = size_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    unique case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          state_d   = BURST;
          arready_d = 1'b0;
          busy_d    = 1'b1;
          id_d      = s_axi_arid;
          burst_d   = s_axi_arburst;
          size_d    = s_axi_arsize;
          len_d     = s_axi_arlen;
          cnt_d     = '0;
          pend_d    = 1'b1;
          idx_d     = s_axi_araddr[DATA_BYTE_SHIFT +: DEPTH_INDEX];
        end
      end
      BURST: begin
        arready_d = 1'b0;
        if (rvalid_q && s_axi_rready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            arready_d = 1'b1;
            rlast_d   = 1'b0;
          end
        end
        // pend_q tracks beats still to fetch; the 8-bit count stops at len_q, so 256 beats fit.
        if ((!rvalid_q || s_axi_rready) && pend_q) begin
          rvalid_d = 1'b1;
          rdata_d  = beat_err ? '0 : mem_rd;
          rresp_d  = beat_err ? RESP_SLVERR : RESP_OKAY;
          rid_d    = id_q;
          rlast_d  = (cnt_q == len_q);
          pend_d   = (cnt_q != len_q);
          cnt_d    = cnt_q + 8'd1;
          idx_d    = idx_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      busy_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
      id_q      <= '0;
      burst_q   <= '0;
      size_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      busy_q    <= busy_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      id_q      <= id_d;
      burst_q   <= burst_d;
      size_q    <= size_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;
  assign busy          = busy_q;

endmodule
